// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer (main + skid registers) decoupling a valid/ready stream.
// Optional zero-latency bypass when empty: define PIPE_SKID_PASSTHRU_EN.
module pipe_skid_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             pass;

  // Bypass is only taken when the item can leave in the same cycle it arrives.
`ifdef PIPE_SKID_PASSTHRU_EN
  assign pass = reset && (state_q == StEmpty) && in_valid && out_ready && !flush;
`else
  assign pass = 1'b0;
`endif

  // in_ready depends on registered state and reset only.
  assign in_ready = reset && (state_q != StFull);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    out_valid = (state_q != StEmpty);
    out_data  = main_q;
    if (pass) begin
      out_valid = 1'b1;
      out_data  = in_data;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      StEmpty: occupancy = 2'd0;
      StBusy:  occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire && !pass) begin
            main_d  = in_data;
            state_d = StBusy;
          end
        end
        StBusy: begin
          if (in_fire && out_ready) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = StFull;
          end else if (out_ready) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_ready) begin
            main_d  = skid_q;
            state_d = StBusy;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: doc/pipe_skid_buffer.md
PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, payload width in bits (legal range 1..64).
REQ-002 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset; logic 0 resets the block.
REQ-004 Port in_valid  input  1  upstream presents in_data.
REQ-005 Port in_ready  output  1  block accepts in_data this cycle.
REQ-006 Port in_data  input  WIDTH  upstream payload.
REQ-007 Port out_valid  output  1  out_data is valid.
REQ-008 Port out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 Port out_data  output  WIDTH  downstream payload.
REQ-010 Port flush  input  1  synchronous discard of all held entries.
REQ-011 Port occupancy  output  2  entries held: 0, 1 or 2.

Function
REQ-012 A transfer (fire) SHALL occur on an input or output side only when its valid and ready are both 1 at a rising clock edge.
REQ-013 Storage SHALL be two WIDTH-bit registers, main and skid, plus a state register with states EMPTY (occupancy 0), BUSY (1) and FULL (2).
REQ-014 in_ready SHALL be 1 exactly when reset is deasserted and state is not FULL; it SHALL have no combinational path from out_ready, in_valid or flush.
REQ-015 out_valid SHALL be 1 exactly when state is not EMPTY, and out_data SHALL equal main, except as stated in REQ-024.
REQ-016 In EMPTY, an input fire SHALL load main and go to BUSY.
REQ-017 In BUSY, input fire with output fire SHALL load main and stay BUSY; input fire alone SHALL load skid and go to FULL; output fire alone SHALL go to EMPTY.
REQ-018 In FULL, output fire SHALL copy skid to main and go to BUSY; no input fire is possible in FULL.
REQ-019 Ordering SHALL be strict FIFO with no loss or duplication; registered-mode latency SHALL be exactly 1 cycle from input fire to out_valid.
REQ-020 flush=1 SHALL force state to EMPTY at the next edge with highest priority over every other event; an input fire in the same cycle SHALL be discarded, and an output fire in the same cycle SHALL still count as delivered.
REQ-021 While in_valid=1 and in_ready=0, upstream SHALL hold in_data stable; the block SHALL capture nothing in that cycle.
REQ-022 A full-rate stream (in_valid=out_ready=1 each cycle) SHALL sustain one transfer per cycle in BUSY.

Reset
REQ-023 While reset=0: state SHALL be EMPTY, main and skid SHALL be 0, out_valid=0, out_data=0, occupancy=0, in_ready=0; in_ready SHALL rise to 1 combinationally on reset deassertion; reset asserted mid-transfer SHALL discard all entries.

Configuration
REQ-024 With macro PIPE_SKID_PASSTHRU_EN defined: in EMPTY with in_valid=1, out_ready=1 and flush=0, out_valid SHALL equal in_valid and out_data SHALL equal in_data combinationally (0-cycle latency), the item SHALL NOT be stored, and the state SHALL remain EMPTY; in EMPTY with out_ready=0, behaviour SHALL follow REQ-016.
REQ-025 Without PIPE_SKID_PASSTHRU_EN: no combinational path SHALL exist from any input data or valid to out_valid or out_data, and REQ-015 and REQ-019 SHALL apply unconditionally.

Verification
REQ-026 Reset then idle: reset=0 for 3 cycles, release -> out_valid=0, occupancy=0, in_ready=1, out_data=0.
REQ-027 Backpressure fill: out_ready=0, push 0xA1, 0xB2, 0xC3 (held) -> occupancy 1 then 2, in_ready=0 after 2nd fire, out_data=0xA1; then out_ready=1 -> 0xA1, 0xB2, 0xC3 delivered in order on consecutive cycles.
REQ-028 Full-rate stream: in_valid=out_ready=1, data 1..100 -> 100 outputs in order, one per cycle, occupancy stays 1 (registered) or 0 (PIPE_SKID_PASSTHRU_EN).
REQ-029 Flush while FULL with simultaneous input: hold 0x11, 0x22, assert flush with in_valid=1 data 0x33 -> next cycle occupancy=0, out_valid=0; 0x33 never appears.
REQ-030 Async reset mid-stream: reset=0 between clock edges while FULL -> occupancy=0 and out_valid=0 immediately, without a clock edge.
REQ-031 Random valid/ready toggling for 10000 cycles against a scoreboard -> no loss, duplication or reorder; in_ready never depends on same-cycle out_ready.
